// File: rtl/lsu_axi.sv
// Load/store unit: one EXU instruction per handshake, one AXI4-lite read or write,
// load extraction/extension, registered WBU result. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_axi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SB_W   = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [2:0]          func3,
  input  logic [SB_W-1:0]     sb_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [SB_W-1:0]     out_sb,
  output logic                out_err,
  output logic                out_misalign,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

  state_t          state;
  logic [OW-1:0]   off;
  logic [2:0]      f3;
  logic [7:0]      strb_base;
  logic [NB-1:0]   strb;
  logic [ADDR_W-1:0] aligned;

  function automatic logic legal_load(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_load = 1'b1;
      3'b011, 3'b110:                         legal_load = (DATA_W == 64);
      default:                                legal_load = 1'b0;
    endcase
  endfunction

  function automatic logic legal_store(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010: legal_store = 1'b1;
      3'b011:                 legal_store = (DATA_W == 64);
      default:                legal_store = 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then size-cast to extend.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [OW-1:0] o,
                                               input logic [2:0] f);
    logic [DATA_W-1:0] s;
    s = d >> {o, 3'b000};
    case (f)
      3'b000:  extend = DATA_W'($signed(s[7:0]));
      3'b100:  extend = DATA_W'(s[7:0]);
      3'b001:  extend = DATA_W'($signed(s[15:0]));
      3'b101:  extend = DATA_W'(s[15:0]);
      3'b010:  extend = DATA_W'($signed(s[31:0]));
      3'b110:  extend = DATA_W'(s[31:0]);
      3'b011:  extend = s;
      default: extend = '0;
    endcase
  endfunction

  always_comb begin
    case (func3[1:0])
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  assign strb    = NB'(strb_base) << addr[OW-1:0];
  assign aligned = {addr[ADDR_W-1:OW], {OW{1'b0}}};

`ifdef LSU_MISALIGN_TRAP_EN
  logic [2:0] size_mask;
  logic       misaligned;

  always_comb begin
    case (func3[1:0])
      2'b00:   size_mask = 3'd0;
      2'b01:   size_mask = 3'd1;
      2'b10:   size_mask = 3'd3;
      default: size_mask = 3'd7;
    endcase
  end

  assign misaligned = (addr[OW-1:0] & OW'(size_mask)) != '0;
`else
  assign out_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      off       <= '0;
      f3        <= '0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_addr  <= '0;
      out_sb    <= '0;
      out_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      out_misalign <= 1'b0;
`endif
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata_o   <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            off       <= addr[OW-1:0];
            f3        <= func3;
            out_addr  <= addr;
            out_sb    <= sb_in;
            out_rdata <= '0;
            out_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            out_misalign <= 1'b0;
`endif
            if (mem_ren || mem_wen) begin
              // Load wins when both requests are set; legality follows the chosen op.
              if (mem_ren ? !legal_load(func3) : !legal_store(func3)) begin
                out_err   <= 1'b1;
                out_valid <= 1'b1;
                state     <= DONE;
              end
`ifdef LSU_MISALIGN_TRAP_EN
              else if (misaligned) begin
                out_misalign <= 1'b1;
                out_valid    <= 1'b1;
                state        <= DONE;
              end
`endif
              else if (mem_ren) begin
                araddr  <= aligned;
                arvalid <= 1'b1;
                state   <= AR;
              end else begin
                awaddr  <= aligned;
                wdata_o <= wdata << {addr[OW-1:0], 3'b000};
                wstrb   <= strb;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                state   <= WR;
              end
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            out_err   <= (rresp != 2'b00);
            out_rdata <= (rresp != 2'b00) ? '0 : extend(rdata, off, f3);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            out_err   <= (bresp != 2'b00);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi.sv
// Directed self-checking bench for lsu_axi (DATA_W=32) with a hand-driven AXI4-lite slave.
module tb_lsu_axi;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         mem_ren;
  logic         mem_wen;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [2:0]   func3;
  logic [127:0] sb_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_rdata;
  logic [31:0]  out_addr;
  logic [127:0] out_sb;
  logic         out_err;
  logic         out_misalign;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata_o;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int checks = 0;
  int errors = 0;

  lsu_axi #(.DATA_W(32), .ADDR_W(32), .SB_W(128)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .addr(addr), .wdata(wdata),
    .func3(func3), .sb_in(sb_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_addr(out_addr), .out_sb(out_sb), .out_err(out_err), .out_misalign(out_misalign),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f, input logic [127:0] sb);
    in_valid = 1'b1; mem_ren = ren; mem_wen = wen;
    addr = a; wdata = wd; func3 = f; sb_in = sb;
    tick();
    in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("done_out_valid_low", out_valid, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; mem_ren = 0; mem_wen = 0; addr = '0; wdata = '0;
    func3 = '0; sb_in = '0; out_ready = 0; arready = 0; rdata = '0; rresp = '0;
    rvalid = 0; awready = 0; wready = 0; bresp = '0; bvalid = 0;
    tick(); tick();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_out_misalign", out_misalign, 1'b0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_sb", out_sb, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // Non-memory op
    issue(1'b0, 1'b0, 32'h0000_1234, 32'h0, 3'b000, 128'hABCD);
    chk("nonmem_out_valid", out_valid, 1'b1);
    chk("nonmem_out_sb", out_sb, 128'hABCD);
    chk("nonmem_out_rdata", out_rdata, 32'h0);
    chk("nonmem_out_addr", out_addr, 32'h0000_1234);
    chk("nonmem_arvalid", arvalid, 1'b0);
    chk("nonmem_awvalid", awvalid, 1'b0);
    chk("nonmem_in_ready", in_ready, 1'b0);
    finish_out();

    // LB, sign-extended
    issue(1'b1, 1'b0, 32'h8000_0003, 32'h0, 3'b000, 128'h1);
    chk("lb_arvalid", arvalid, 1'b1);
    chk("lb_araddr", araddr, 32'h8000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("lb_arvalid_drop", arvalid, 1'b0);
    chk("lb_rready", rready, 1'b1);
    rdata = 32'h80FF_0000; rresp = 2'b00; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("lb_out_valid", out_valid, 1'b1);
    chk("lb_out_rdata", out_rdata, 32'hFFFF_FF80);
    chk("lb_out_err", out_err, 1'b0);
    chk("lb_rready_drop", rready, 1'b0);
    finish_out();

    // LBU, zero-extended
    issue(1'b1, 1'b0, 32'h8000_0003, 32'h0, 3'b100, 128'h2);
    chk("lbu_araddr", araddr, 32'h8000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rdata = 32'h80FF_0000; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("lbu_out_rdata", out_rdata, 32'h0000_0080);
    finish_out();

    // SH with awready three cycles before wready
    issue(1'b0, 1'b1, 32'h8000_0002, 32'h0000_1234, 3'b001, 128'h3);
    chk("sh_awvalid", awvalid, 1'b1);
    chk("sh_wvalid", wvalid, 1'b1);
    chk("sh_awaddr", awaddr, 32'h8000_0000);
    chk("sh_wstrb", wstrb, 4'hC);
    chk("sh_wdata_o", wdata_o, 32'h1234_0000);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("sh_awvalid_drop", awvalid, 1'b0);
    chk("sh_wvalid_hold", wvalid, 1'b1);
    tick(); tick();
    chk("sh_wvalid_hold2", wvalid, 1'b1);
    chk("sh_bready_wait", bready, 1'b0);
    chk("sh_wdata_stable", wdata_o, 32'h1234_0000);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("sh_wvalid_drop", wvalid, 1'b0);
    chk("sh_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("sh_out_valid", out_valid, 1'b1);
    chk("sh_out_err", out_err, 1'b0);
    chk("sh_out_rdata", out_rdata, 32'h0);
    finish_out();

    // SB, both channels accepted together, error response
    issue(1'b0, 1'b1, 32'h8000_0101, 32'h0000_00AB, 3'b000, 128'h4);
    chk("sb_wstrb", wstrb, 4'h2);
    chk("sb_wdata_o", wdata_o, 32'h0000_AB00);
    chk("sb_awaddr", awaddr, 32'h8000_0100);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("sb_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk("sb_out_err", out_err, 1'b1);
    finish_out();

    // LW with read error, WBU stalled for 5 cycles
    issue(1'b1, 1'b0, 32'h8000_0004, 32'h0, 3'b010, 128'h5);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rdata = 32'hDEAD_BEEF; rresp = 2'b10; rvalid = 1'b1;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    in_valid = 1'b1; sb_in = 128'h55;
    for (int i = 0; i < 5; i++) begin
      chk("rerr_out_valid", out_valid, 1'b1);
      chk("rerr_out_err", out_err, 1'b1);
      chk("rerr_out_rdata", out_rdata, 32'h0);
      chk("rerr_out_sb", out_sb, 128'h5);
      chk("rerr_in_ready", in_ready, 1'b0);
      tick();
    end
    // in_valid held through the DONE handshake: accepted only a cycle later
    out_ready = 1'b1;
    tick();
    chk("nextacc_out_valid", out_valid, 1'b0);
    chk("nextacc_in_ready", in_ready, 1'b1);
    chk("nextacc_out_sb_old", out_sb, 128'h5);
    tick();
    in_valid = 1'b0;
    chk("nextacc_accepted", out_valid, 1'b1);
    chk("nextacc_out_sb", out_sb, 128'h55);
    chk("nextacc_out_err", out_err, 1'b0);
    tick();
    out_ready = 1'b0;
    chk("nextacc_done", out_valid, 1'b0);

    // Illegal func3: no bus activity
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'b011, 128'h6);
    chk("ill_ld_out_valid", out_valid, 1'b1);
    chk("ill_ld_out_err", out_err, 1'b1);
    chk("ill_ld_arvalid", arvalid, 1'b0);
    finish_out();
    issue(1'b0, 1'b1, 32'h8000_0000, 32'h0, 3'b111, 128'h7);
    chk("ill_st_out_err", out_err, 1'b1);
    chk("ill_st_awvalid", awvalid, 1'b0);
    chk("ill_st_wvalid", wvalid, 1'b0);
    finish_out();

    // Misaligned LW
    issue(1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b010, 128'h8);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_arvalid", arvalid, 1'b0);
    chk("mis_out_valid", out_valid, 1'b1);
    chk("mis_out_misalign", out_misalign, 1'b1);
    chk("mis_out_err", out_err, 1'b0);
`else
    chk("mis_arvalid", arvalid, 1'b1);
    chk("mis_araddr", araddr, 32'h8000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rdata = 32'h1122_3344; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    chk("mis_out_rdata", out_rdata, 32'h0000_1122);
    chk("mis_out_misalign", out_misalign, 1'b0);
`endif
    finish_out();

    // Reset while arvalid awaits arready
    issue(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 128'h9);
    chk("rstmid_arvalid", arvalid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_arvalid_drop", arvalid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rstmid_in_ready", in_ready, 1'b1);
    chk("rstmid_arvalid_idle", arvalid, 1'b0);
    chk("rstmid_out_valid", out_valid, 1'b0);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 128'hA);
    chk("rstmid_nonmem", out_valid, 1'b1);
    chk("rstmid_nonmem_sb", out_sb, 128'hA);
    finish_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
